// File: rtl/light_pkg.sv
// Shared definitions for the light arbiter controller: FSM state type and encodings.
package light_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_OFF  = 2'b00;
    localparam state_t ST_ON   = 2'b01;
    localparam state_t ST_WARN = 2'b10;

endpackage

// File: rtl/light_arbiter_ctrl_if.sv
// Button/light bundle between the wall-switch side (master) and the controller (slave).
interface light_arbiter_ctrl_if
    import light_pkg::*;
#(
    parameter int unsigned N_BTN = 4
);

    logic [N_BTN-1:0] sButton;
    logic             sLuz;
    logic [N_BTN-1:0] sGrant;
    state_t           sState;

    modport master (
        output sButton,
        input  sLuz,
        input  sGrant,
        input  sState
    );

    modport slave (
        input  sButton,
        output sLuz,
        output sGrant,
        output sState
    );

endinterface

// File: rtl/button_sync_edge.sv
// Two-flop synchronizer for one raw button level followed by a rising-edge detector.
module button_sync_edge (
    input  logic sClk,
    input  logic sReset,
    input  logic sButton,
    output logic sPress
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge sClk or negedge sReset) begin
        if (!sReset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sButton;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // A held button yields a single press.
    assign sPress = sync2_q & ~prev_q;

endmodule

// File: rtl/light_arbiter_ctrl.sv
// Shared light controller: per-button sync/edge detect, round-robin arbiter, OFF/ON/WARN FSM.
// Define LUZ_AUTO_OFF_EN to build the auto-off timer, WARN state and blink; else OFF<->ON only.
module light_arbiter_ctrl
    import light_pkg::*;
#(
    parameter int unsigned N_BTN    = 4,
    parameter int unsigned TIMEOUT  = 1000,
    parameter int unsigned WARN_CYC = 100,
    parameter int unsigned BLINK    = 10
) (
    input logic                 sClk,
    input logic                 sReset,
    light_arbiter_ctrl_if.slave bus
);

    localparam int unsigned PW = $clog2(N_BTN);

    if (N_BTN < 2 || N_BTN > 8 || TIMEOUT < 2 || WARN_CYC < 2 || BLINK < 1 || BLINK >= WARN_CYC)
    begin : g_bad_cfg
        $error("light_arbiter_ctrl: illegal parameter set");
    end

    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] pending_q, pending_d;
    logic [N_BTN-1:0] grant_vec;
    logic [N_BTN-1:0] grant_q;
    logic             grant_any;
    logic [PW-1:0]    grant_idx;
    logic [PW-1:0]    ptr_q, ptr_d;
    state_t           state_q, state_d;
    logic             luz_q, luz_d;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        button_sync_edge u_sync (
            .sClk    (sClk),
            .sReset  (sReset),
            .sButton (bus.sButton[i]),
            .sPress  (press[i])
        );
    end

    // First pending requester at or after the pointer, wrapping.
    always_comb begin
        logic [PW-1:0] cand;
        grant_vec = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_BTN; k++) begin
            cand = PW'((32'(ptr_q) + 32'(k)) % N_BTN);
            if (!grant_any && pending_q[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_any) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // A press in the same cycle as its own grant re-arms the request.
    always_comb begin
        pending_d = (pending_q & ~grant_vec) | press;
        ptr_d     = ptr_q;
        if (grant_any) begin
            ptr_d = PW'((32'(grant_idx) + 32'd1) % N_BTN);
        end
    end

`ifdef LUZ_AUTO_OFF_EN
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam int unsigned WW = $clog2(WARN_CYC);
    localparam int unsigned BW = (BLINK > 1) ? $clog2(BLINK) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WCNT_LAST  = WW'(WARN_CYC - 1);
    localparam logic [BW-1:0] BCNT_LAST  = BW'(BLINK - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        case (state_q)
            ST_OFF: begin
                if (grant_any) begin
                    state_d = ST_ON;
                    timer_d = '0;
                end
            end
            ST_ON: begin
                if (grant_any) begin
                    state_d = ST_OFF;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = ST_WARN;
                    wcnt_d  = '0;
                    bcnt_d  = '0;
                    phase_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WARN: begin
                // A grant during the warning extends the light instead of turning it off.
                if (grant_any) begin
                    state_d = ST_ON;
                    timer_d = '0;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d = ST_OFF;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (bcnt_q == BCNT_LAST) begin
                        bcnt_d  = '0;
                        phase_d = ~phase_q;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_OFF;
        endcase
        luz_d = (state_d == ST_ON) || ((state_d == ST_WARN) && phase_d);
    end

    always_ff @(posedge sClk or negedge sReset) begin
        if (!sReset) begin
            timer_q <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else begin
            timer_q <= timer_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end
`else
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:  if (grant_any) state_d = ST_ON;
            ST_ON:   if (grant_any) state_d = ST_OFF;
            ST_WARN: state_d = ST_OFF;
            default: state_d = ST_OFF;
        endcase
        luz_d = (state_d == ST_ON);
    end
`endif

    always_ff @(posedge sClk or negedge sReset) begin
        if (!sReset) begin
            pending_q <= '0;
            ptr_q     <= '0;
            state_q   <= ST_OFF;
            grant_q   <= '0;
            luz_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            state_q   <= state_d;
            grant_q   <= grant_vec;
            luz_q     <= luz_d;
        end
    end

    assign bus.sLuz   = luz_q;
    assign bus.sGrant = grant_q;
    assign bus.sState = state_q;

endmodule

// File: tb/tb_light_arbiter_ctrl.sv
// Self-checking bench for light_arbiter_ctrl: directed scenarios plus random button traffic
// compared every cycle against a behavioural model.
module tb_light_arbiter_ctrl;

    localparam int unsigned N        = 4;
    localparam int unsigned IW       = 2;
    localparam int unsigned TIMEOUT  = 20;
    localparam int unsigned WARN_CYC = 8;
    localparam int unsigned BLINK    = 2;

    logic         sClk;
    logic         sReset;
    logic [N-1:0] btn;
    int           n_chk  = 0;
    int           n_fail = 0;
    bit           cmp_en = 1'b0;
    int           cyc    = 0;

    light_arbiter_ctrl_if #(.N_BTN(N)) bus ();
    assign bus.sButton = btn;

    light_arbiter_ctrl #(
        .N_BTN    (N),
        .TIMEOUT  (TIMEOUT),
        .WARN_CYC (WARN_CYC),
        .BLINK    (BLINK)
    ) dut (
        .sClk   (sClk),
        .sReset (sReset),
        .bus    (bus)
    );

    initial begin
        sClk = 1'b0;
        forever #5 sClk = ~sClk;
    end

    // Behavioural model: sample history, pending set, pointer, and elapsed-cycle counts.
    logic [N-1:0] m_h1 = '0, m_h2 = '0, m_h3 = '0;
    logic [N-1:0] m_pend = '0, m_grant = '0, m_press = '0;
    int           m_ptr = 0, m_st = 0, m_on = 0, m_warn = 0, m_g = -1;
    logic         m_luz = 1'b0;
    logic [1:0]   m_state = 2'b00;

    initial begin
        forever begin
            @(posedge sClk or negedge sReset);
            if (!sReset) begin
                m_h1 = '0; m_h2 = '0; m_h3 = '0;
                m_pend = '0; m_grant = '0; m_ptr = 0;
                m_st = 0; m_on = 0; m_warn = 0;
            end else begin
                cyc++;
                m_press = m_h2 & ~m_h3;
                m_g = -1;
                for (int k = 0; k < N; k++) begin
                    if (m_g < 0 && m_pend[IW'((m_ptr + k) % N)]) m_g = (m_ptr + k) % N;
                end
                m_grant = '0;
                if (m_g >= 0) begin
                    m_grant[IW'(m_g)] = 1'b1;
                    m_ptr = (m_g + 1) % N;
                end
                m_pend = (m_pend & ~m_grant) | m_press;
`ifdef LUZ_AUTO_OFF_EN
                case (m_st)
                    0: if (m_g >= 0) begin m_st = 1; m_on = 0; end
                    1: begin
                        if (m_g >= 0) m_st = 0;
                        else if (m_on == TIMEOUT - 1) begin m_st = 2; m_warn = 0; end
                        else m_on++;
                    end
                    default: begin
                        if (m_g >= 0) begin m_st = 1; m_on = 0; end
                        else if (m_warn == WARN_CYC - 1) m_st = 0;
                        else m_warn++;
                    end
                endcase
`else
                if (m_g >= 0) m_st = 1 - m_st;
`endif
                m_h3 = m_h2; m_h2 = m_h1; m_h1 = btn;
            end
            m_state = 2'(m_st);
            m_luz = (m_st == 1) || (m_st == 2 && ((m_warn / BLINK) % 2) == 0);
        end
    end

    initial begin
        forever begin
            @(negedge sClk);
            if (cmp_en) begin
                n_chk++;
                if (bus.sGrant !== m_grant || bus.sLuz !== m_luz || bus.sState !== m_state) begin
                    n_fail++;
                    $display("FAIL model_cmp cyc=%0d got grant=%b luz=%b state=%b expected grant=%b luz=%b state=%b",
                             cyc, bus.sGrant, bus.sLuz, bus.sState, m_grant, m_luz, m_state);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sClk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v);
        @(negedge sClk);
        btn = v;
    endtask

    task automatic do_reset();
        @(negedge sClk);
        #2 sReset = 1'b0;
        @(negedge sClk);
        #2 sReset = 1'b1;
    endtask

    logic [7:0] blink_exp;

    initial begin
        blink_exp = 8'b0011_0011;
        btn = '0;
        sReset = 1'b1;
        #1 sReset = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (3) @(posedge sClk);
        @(negedge sClk);
        #2 sReset = 1'b1;
        tick(1);
        chk("rst_state", 32'(bus.sState), 32'h0);
        chk("rst_luz", 32'(bus.sLuz), 32'h0);
        chk("rst_grant", 32'(bus.sGrant), 32'h0);

        // Single press held five samples: one grant, light on 3 edges after first sample.
        drive(4'b0001);
        tick(3);
        chk("t1_luz_before", 32'(bus.sLuz), 32'h0);
        chk("t1_grant_before", 32'(bus.sGrant), 32'h0);
        tick(1);
        chk("t1_grant", 32'(bus.sGrant), 32'h1);
        chk("t1_luz", 32'(bus.sLuz), 32'h1);
        chk("t1_state", 32'(bus.sState), 32'h1);
        tick(1);
        chk("t1_grant_once", 32'(bus.sGrant), 32'h0);
        drive(4'b0000);
        tick(4);
        chk("t1_hold_state", 32'(bus.sState), 32'h1);

        // Three simultaneous presses from OFF are served in pointer order.
        do_reset();
        drive(4'b1110);
        tick(1);
        drive(4'b0000);
        tick(3);
        chk("t2_grant1", 32'(bus.sGrant), 32'h2);
        chk("t2_luz1", 32'(bus.sLuz), 32'h1);
        tick(1);
        chk("t2_grant2", 32'(bus.sGrant), 32'h4);
        chk("t2_luz2", 32'(bus.sLuz), 32'h0);
        tick(1);
        chk("t2_grant3", 32'(bus.sGrant), 32'h8);
        chk("t2_luz3", 32'(bus.sLuz), 32'h1);

`ifdef LUZ_AUTO_OFF_EN
        // Timeout into WARN, blink pattern, then forced off.
        tick(19);
        chk("t3_still_on", 32'(bus.sState), 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("t3_warn_state", 32'(bus.sState), 32'h2);
            chk("t3_blink", 32'(bus.sLuz), 32'(blink_exp[i]));
        end
        tick(1);
        chk("t3_off_state", 32'(bus.sState), 32'h0);
        chk("t3_off_luz", 32'(bus.sLuz), 32'h0);

        // Press during WARN at wcnt=3 extends the light and restarts the timer.
        drive(4'b0001);
        tick(1);
        drive(4'b0000);
        tick(22);
        chk("t4_on", 32'(bus.sState), 32'h1);
        tick(1);
        chk("t4_warn", 32'(bus.sState), 32'h2);
        drive(4'b0100);
        tick(1);
        drive(4'b0000);
        tick(2);
        chk("t4_warn_w3", 32'(bus.sState), 32'h2);
        chk("t4_luz_w3", 32'(bus.sLuz), 32'h0);
        tick(1);
        chk("t4_grant", 32'(bus.sGrant), 32'h4);
        chk("t4_state", 32'(bus.sState), 32'h1);
        chk("t4_luz", 32'(bus.sLuz), 32'h1);
        tick(19);
        chk("t4_restart_on", 32'(bus.sState), 32'h1);
        tick(1);
        chk("t4_restart_warn", 32'(bus.sState), 32'h2);

        // Two presses on btn0 while it waits behind btn1..3 collapse into one grant.
        drive(4'b0001);
        tick(1);
        drive(4'b0000);
        tick(4);
        drive(4'b1111);
        tick(1);
        drive(4'b0000);
        tick(1);
        drive(4'b0001);
        tick(1);
        drive(4'b0000);
        tick(1);
        chk("t5_g1", 32'(bus.sGrant), 32'h2);
        tick(1);
        chk("t5_g2", 32'(bus.sGrant), 32'h4);
        tick(1);
        chk("t5_g3", 32'(bus.sGrant), 32'h8);
        tick(1);
        chk("t5_g0", 32'(bus.sGrant), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("t5_no_regrant", 32'(bus.sGrant), 32'h0);
        end

        // Async reset in WARN with btn3 pending: everything cleared, no replay.
        tick(16);
        chk("t6_warn", 32'(bus.sState), 32'h2);
        drive(4'b1000);
        tick(1);
        drive(4'b0000);
        tick(2);
        chk("t6_pre_reset", 32'(bus.sState), 32'h2);
        #1 sReset = 1'b0;
        #1;
        chk("t6_rst_luz", 32'(bus.sLuz), 32'h0);
        chk("t6_rst_state", 32'(bus.sState), 32'h0);
        chk("t6_rst_grant", 32'(bus.sGrant), 32'h0);
        @(negedge sClk);
        @(negedge sClk);
        #2 sReset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("t6_no_replay", 32'(bus.sGrant), 32'h0);
        end
        chk("t6_off", 32'(bus.sState), 32'h0);
`else
        drive(4'b0001);
        tick(1);
        drive(4'b0000);
        tick(3);
        chk("t3_grant", 32'(bus.sGrant), 32'h1);
        chk("t3_state", 32'(bus.sState), 32'h0);
        chk("t3_luz", 32'(bus.sLuz), 32'h0);
`endif

        // Random traffic: busy phase then sparse phase so timeouts occur.
        for (int c = 0; c < 2500; c++) begin
            @(negedge sClk);
            if ($urandom_range(0, (c < 1200) ? 4 : 59) == 0) begin
                btn = btn ^ (N'(1) << $urandom_range(0, N - 1));
            end
            if ($urandom_range(0, 299) == 0) begin
                #2 sReset = 1'b0;
                @(negedge sClk);
                #2 sReset = 1'b1;
            end
        end
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/light_arbiter_ctrl.md
Name: light_arbiter_ctrl

Overview:
Controller for the shared on/off light (sLuz) driven by several wall buttons. It synchronizes and edge-detects each button and latches one pending toggle request per button. A round-robin arbiter grants at most one request per cycle, and a small FSM sequences the light through OFF/ON/WARN with an auto-off timer. It replaces direct button-to-flop wiring at the switch level.

Parameters:
N_BTN, 4, number of button requesters (2..8)
TIMEOUT, 1000, cycles in ON before entering WARN (>=2)
WARN_CYC, 100, cycles spent in WARN before forced OFF (>=2)
BLINK, 10, half-period in cycles of the WARN blink (>=1, < WARN_CYC)

Ports:
sClk  in  1  clock, rising edge
sReset  in  1  asynchronous, active-low reset
sButton  in  N_BTN  raw asynchronous button levels, bit i = requester i
sLuz  out  1  light drive
sGrant  out  N_BTN  registered one-hot pulse, one cycle, marks the requester serviced
sState  out  2  current FSM state (OFF=00, ON=01, WARN=10)

Behaviour:
- Reset (sReset=0, async): sLuz=0, sGrant=0, sState=OFF, sync/prev/pending regs=0, rr pointer=0, counters=0, blink phase=1.
- Per button: 2-flop synchronizer, then prev reg; press = sync2 & ~prev (rising edge only; a held button is one press).
- Pending[i] is set on press[i] and cleared on grant[i]. A press coinciding with its own grant leaves pending set. Repeat presses while pending coalesce into one.
- Arbiter: combinational pick of the first pending index at or after the pointer, wrapping mod N_BTN. At most one grant per cycle. After granting i, pointer = (i+1) mod N_BTN. With no pending, the pointer holds.
- Latency: button first sampled high at edge t -> pending at t+2 -> grant/state update at t+3 (uncontested); sGrant high for the cycle after edge t+3.
- FSM (grant = any grant this cycle):
  OFF: grant -> ON, timer=0.
  ON: grant -> OFF. Else if timer==TIMEOUT-1 -> WARN, wcnt=0, phase=1. Else timer++.
  WARN: grant -> ON, timer=0 (extend, not off). Else if wcnt==WARN_CYC-1 -> OFF. Else wcnt++. Phase toggles when (wcnt+1)%BLINK==0.
  Illegal encoding 11 -> OFF next cycle.
- Grant and expiry in the same cycle: grant wins.
- sLuz (registered): OFF=0, ON=1, WARN=phase.
- Counter widths: $clog2(TIMEOUT) and $clog2(WARN_CYC), no overflow by construction.
- Reset asserted mid-operation drops all pending requests. There is no replay after release.

Optional Feature:
LUZ_AUTO_OFF_EN
- Defined: timer, WARN state and blink exist as above.
- Undefined: no counters; FSM is OFF<->ON on grant only. sState never reports 10. TIMEOUT, WARN_CYC and BLINK are ignored.

Decomposition:
- Package light_pkg: state encoding constants ST_OFF=2'b00, ST_ON=2'b01, ST_WARN=2'b10, and the state typedef.
- Sub-module button_sync_edge: 2-flop synchronizer plus edge detect, one instance per button (generate loop), ports sClk, sReset, sButton, sPress.
- Arbiter and FSM stay in the top.

Test Plan:
(bench params N_BTN=4, TIMEOUT=20, WARN_CYC=8, BLINK=2, LUZ_AUTO_OFF_EN defined)
- Reset then press btn0 (high 5 cycles) -> sGrant=0001 once, sLuz 0->1 exactly 3 edges after first sample, sState=01. Holding does not toggle again.
- Press btn1, btn2, btn3 in the same cycle from OFF -> grants 0010, 0100, 1000 on consecutive cycles. sLuz toggles 1,0,1; pointer ends at 0.
- Light ON, no presses -> sState=10 after 20 cycles. sLuz blinks 1,1,0,0,1,1,0,0 over 8 cycles, then sState=00, sLuz=0.
- In WARN at wcnt=3, press btn2 -> sState=01, sLuz=1, timer restarts (WARN again 20 cycles later).
- Press btn0 twice while its pending is still set (btn1 holding arbiter) -> single grant to btn0.
- sReset=0 asynchronously mid-WARN with pending on btn3 -> immediate sLuz=0, sState=00. After release, no grant occurs without a new press.
